// File: rtl/cpu_pkg.sv
// cpu_pkg: shared datapath constants and the PC sequencer state encoding.
//   XLEN        - datapath / PC width in bits
//   INSTR_BYTES - size of one instruction in bytes (sequential PC step)
//   pc_state_t  - sequencer FSM states (BOOT, RUN, HALT)
package cpu_pkg;

  localparam int XLEN        = 64;
  localparam int INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } pc_state_t;

endpackage

// File: rtl/flopenr.sv
// flopenr: register with load enable and synchronous reset to a parameter value.
//   clk   - rising-edge clock
//   reset - synchronous, active-high; loads RESET_VAL
//   en    - load d when high, otherwise hold
//   d     - next value
//   q     - registered value
module flopenr #(
  parameter int                WIDTH     = 64,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= RESET_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: next-PC generation and program-counter state.
// Selects the next PC from halt / stall / register-indirect / PC-relative /
// sequential sources (in that priority), holds across stalls, freezes on HALT,
// and counts PC advances.
// Optional build macro: PC_MISALIGN_TRAP_EN - a redirect target with nonzero
// bits [1:0] is not loaded; the sequencer halts and raises sticky misalign_err.
// Ports:
//   clk, reset            - clock and synchronous active-high reset
//   stall                 - hold PC this cycle
//   branch_taken/_offset  - PC-relative redirect, offset in words
//   br_reg_en/_target     - register-indirect redirect, absolute byte address
//   halt_req              - current instruction is HALT
//   pc, pc_plus4          - current PC and its sequential successor
//   fetch_valid, halted   - RUN / HALT status
//   retired               - count of PC advances
//   misalign_err          - sticky misaligned-target flag (0 without the macro)
module pc_sequencer
  import cpu_pkg::*;
#(
  parameter int               XLEN     = cpu_pkg::XLEN,
  parameter logic [XLEN-1:0]  RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_offset,
  input  logic            br_reg_en,
  input  logic [XLEN-1:0] br_reg_target,
  input  logic            halt_req,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            fetch_valid,
  output logic            halted,
  output logic [XLEN-1:0] retired,
  output logic            misalign_err
);

  pc_state_t       state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            pc_en;
  logic [XLEN-1:0] retired_q, retired_d;

`ifdef PC_MISALIGN_TRAP_EN
  logic            misalign_q, misalign_d;
  logic            redirect;
`endif

  flopenr #(
    .WIDTH     (XLEN),
    .RESET_VAL (RESET_PC)
  ) u_pc_reg (
    .clk   (clk),
    .reset (reset),
    .en    (pc_en),
    .d     (pc_d),
    .q     (pc_q)
  );

  assign pc_plus4 = pc_q + XLEN'(INSTR_BYTES);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    pc_en     = 1'b0;
    retired_d = retired_q;
`ifdef PC_MISALIGN_TRAP_EN
    misalign_d = misalign_q;
    redirect   = 1'b0;
`endif
    case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (halt_req) begin
          state_d = HALT;
        end else if (!stall) begin
          if (br_reg_en) begin
            pc_d = br_reg_target;
`ifdef PC_MISALIGN_TRAP_EN
            redirect = 1'b1;
`endif
          end else if (branch_taken) begin
            // Word offset scaled to bytes; wraps modulo 2^XLEN.
            pc_d = pc_q + (branch_offset << 2);
`ifdef PC_MISALIGN_TRAP_EN
            redirect = 1'b1;
`endif
          end else begin
            pc_d = pc_plus4;
          end
`ifdef PC_MISALIGN_TRAP_EN
          if (redirect && (pc_d[1:0] != 2'b00)) begin
            state_d    = HALT;
            misalign_d = 1'b1;
          end else begin
            pc_en     = 1'b1;
            retired_d = retired_q + 1'b1;
          end
`else
          pc_en     = 1'b1;
          retired_d = retired_q + 1'b1;
`endif
        end
      end
      HALT:    state_d = HALT;
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= BOOT;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

`ifdef PC_MISALIGN_TRAP_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_d;
    end
  end
  assign misalign_err = misalign_q;
`else
  assign misalign_err = 1'b0;
`endif

  assign pc          = pc_q;
  assign retired     = retired_q;
  assign fetch_valid = (state_q == RUN);
  assign halted      = (state_q == HALT);

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed-vector bench for pc_sequencer (RESET_PC = 0x1000).
module tb_pc_sequencer;

  localparam int W = 64;

  logic         clk = 1'b0;
  logic         reset;
  logic         stall;
  logic         branch_taken;
  logic [W-1:0] branch_offset;
  logic         br_reg_en;
  logic [W-1:0] br_reg_target;
  logic         halt_req;
  logic [W-1:0] pc;
  logic [W-1:0] pc_plus4;
  logic         fetch_valid;
  logic         halted;
  logic [W-1:0] retired;
  logic         misalign_err;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  pc_sequencer #(
    .XLEN     (W),
    .RESET_PC (64'h1000)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset),
    .br_reg_en     (br_reg_en),
    .br_reg_target (br_reg_target),
    .halt_req      (halt_req),
    .pc            (pc),
    .pc_plus4      (pc_plus4),
    .fetch_valid   (fetch_valid),
    .halted        (halted),
    .retired       (retired),
    .misalign_err  (misalign_err)
  );

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    stall = 0; branch_taken = 0; branch_offset = '0;
    br_reg_en = 0; br_reg_target = '0; halt_req = 0;
  endtask

  task automatic jump_reg(input logic [W-1:0] tgt);
    idle();
    br_reg_en = 1; br_reg_target = tgt;
    step();
    idle();
  endtask

  initial begin
    idle();
    reset = 1;
    step(); step();
    check("rst_pc", pc, 64'h1000);
    check("rst_fv", {63'd0, fetch_valid}, 64'd0);
    check("rst_halted", {63'd0, halted}, 64'd0);
    check("rst_retired", retired, 64'd0);
    check("rst_misalign", {63'd0, misalign_err}, 64'd0);
    check("rst_pc4", pc_plus4, 64'h1004);

    // Release: BOOT cycle, then RUN at RESET_PC, then sequential advance.
    reset = 0;
    check("boot_pc", pc, 64'h1000);
    step();
    check("run1_pc", pc, 64'h1000);
    check("run1_fv", {63'd0, fetch_valid}, 64'd1);
    step();
    check("seq1_pc", pc, 64'h1004);
    step();
    check("seq2_pc", pc, 64'h1008);
    check("seq2_retired", retired, 64'd2);

    // Stall holds PC and count.
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_pc", pc, 64'h1008);
      check("stall_retired", retired, 64'd2);
    end
    stall = 0;
    step();
    check("post_stall_pc", pc, 64'h100C);
    check("post_stall_retired", retired, 64'd3);

    // BR beats PC-relative branch when both asserted.
    br_reg_en = 1; br_reg_target = 64'h4000;
    branch_taken = 1; branch_offset = 64'd100;
    step();
    idle();
    check("br_prio_pc", pc, 64'h4000);
    check("br_prio_retired", retired, 64'd4);

    // PC-relative branches, negative and positive word offsets.
    jump_reg(64'h2000);
    branch_taken = 1; branch_offset = -64'sd2;
    step(); idle();
    check("bneg_pc", pc, 64'h1FF8);
    jump_reg(64'h2000);
    branch_taken = 1; branch_offset = 64'h10;
    step(); idle();
    check("bpos_pc", pc, 64'h2040);
    check("branch_retired", retired, 64'd8);

    // Sequential wrap at top of address space.
    jump_reg(64'hFFFF_FFFF_FFFF_FFFC);
    check("top_pc4", pc_plus4, 64'd0);
    step();
    check("wrap_pc", pc, 64'd0);
    check("wrap_retired", retired, 64'd10);

    // Halt has priority over stall and redirects; then frozen.
    jump_reg(64'h1010);
    halt_req = 1; stall = 1; br_reg_en = 1; br_reg_target = 64'h8000;
    step();
    idle();
    br_reg_en = 1; br_reg_target = 64'h8000;
    check("halt_halted", {63'd0, halted}, 64'd1);
    check("halt_fv", {63'd0, fetch_valid}, 64'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      check("halt_pc", pc, 64'h1010);
      check("halt_retired", retired, 64'd11);
      check("halt_stays", {63'd0, halted}, 64'd1);
    end

    // Reset out of HALT; BOOT ignores a pending halt request.
    idle();
    reset = 1;
    step();
    check("rst2_pc", pc, 64'h1000);
    check("rst2_halted", {63'd0, halted}, 64'd0);
    check("rst2_retired", retired, 64'd0);
    reset = 0;
    halt_req = 1;
    step();
    idle();
    check("boot_ignore_halted", {63'd0, halted}, 64'd0);
    check("boot_ignore_fv", {63'd0, fetch_valid}, 64'd1);
    check("boot_ignore_pc", pc, 64'h1000);

    // Misaligned BR target.
    jump_reg(64'h4002);
`ifdef PC_MISALIGN_TRAP_EN
    check("mis_err", {63'd0, misalign_err}, 64'd1);
    check("mis_halted", {63'd0, halted}, 64'd1);
    check("mis_pc", pc, 64'h1000);
    check("mis_retired", retired, 64'd0);
    step();
    check("mis_sticky", {63'd0, misalign_err}, 64'd1);
`else
    check("mis_pc", pc, 64'h4002);
    check("mis_err", {63'd0, misalign_err}, 64'd0);
    check("mis_retired", retired, 64'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Next-PC generation and program-counter state for the single-cycle datapath. Sits directly upstream of the PC register path and instruction memory: computes the next PC from sequential, PC-relative branch and register-indirect sources, holds it across stalls, and stops cleanly on halt. Drives instruction-memory address and `pc_plus4` to the writeback mux (BL link value).

## Interface
Parameters:
- `XLEN`, 64, datapath/PC width in bits.
- `RESET_PC`, 64'h0, PC value loaded by reset.

Ports (one clock; reset is synchronous and active-high):
- `clk`  input  1  rising-edge clock.
- `reset`  input  1  synchronous, active-high.
- `stall`  input  1  hold PC this cycle.
- `branch_taken`  input  1  PC-relative branch/B/CBZ resolved taken.
- `branch_offset`  input  XLEN  sign-extended word offset from decode.
- `br_reg_en`  input  1  register-indirect jump (BR).
- `br_reg_target`  input  XLEN  absolute target from register file.
- `halt_req`  input  1  current instruction is HALT.
- `pc`  output  XLEN  current PC, to instruction memory.
- `pc_plus4`  output  XLEN  `pc + 4`, combinational.
- `fetch_valid`  output  1  instruction at `pc` is to be executed.
- `halted`  output  1  sequencer in HALT.
- `retired`  output  XLEN  count of PC advances (instructions completed).
- `misalign_err`  output  1  sticky; only with `PC_MISALIGN_TRAP_EN`.

## Operation
- FSM states: BOOT, RUN, HALT (enum in package).
- Reset (any state, any cycle): `pc`=RESET_PC, state=BOOT, `fetch_valid`=0, `halted`=0, `retired`=0, `misalign_err`=0.
- BOOT: one cycle, PC held, inputs ignored; -> RUN unconditionally.
- RUN, `fetch_valid`=1. Next-PC priority: `halt_req` > `stall` > `br_reg_en` > `branch_taken` > sequential.
  - `halt_req`: PC held, -> HALT, `retired` not incremented.
  - `stall`: PC and `retired` held.
  - `br_reg_en`: next = `br_reg_target`.
  - `branch_taken`: next = `pc + (branch_offset << 2)`, modulo 2^XLEN.
  - otherwise: next = `pc + 4`, modulo 2^XLEN (0xFFFF_FFFF_FFFF_FFFC wraps to 0).
  - Each non-stall, non-halt RUN cycle increments `retired` by 1 (wraps).
- HALT: PC, `retired` frozen; `fetch_valid`=0, `halted`=1; leaves only via reset.
- `br_reg_en` and `branch_taken` both high: `br_reg_en` wins.

## Timing
- `pc`, `fetch_valid`, `halted`, `retired`, `misalign_err` registered; update on rising `clk`.
- `pc_plus4` combinational from registered `pc`, zero added latency.
- Control inputs sampled at the edge ending the cycle; redirect visible on `pc` one cycle later; no delay slot.
- After reset deasserts: first edge -> RUN (`pc`=RESET_PC, `fetch_valid`=1); second edge advances PC.
- `halted` asserts on the edge after `halt_req` sampled in RUN.

## Configuration
- `PC_MISALIGN_TRAP_EN` defined: a selected next PC (branch or BR) with bits [1:0] ≠ 0 is not loaded; state -> HALT, `misalign_err` set (sticky until reset), `retired` not incremented.
- Undefined: next PC loaded as computed, `misalign_err` tied 0.

## Structure
- Package `cpu_pkg`: `XLEN`, `INSTR_BYTES`=4, `pc_state_t` (BOOT/RUN/HALT).
- Sub-module `flopenr` (enable + synchronous reset to parameter value) for the PC register; next-PC mux, counter, FSM in this module.

## Test plan
- Reset with RESET_PC=0x1000, release, 4 free cycles -> `pc` 0x1000, 0x1000, 0x1004, 0x1008; `retired`=2.
- At `pc`=0x2000, `branch_taken`=1, `branch_offset`=-2 -> next `pc`=0x1FF8; offset 0x10 -> 0x2040.
- `stall` 3 cycles at 0x1008 -> `pc`, `retired` unchanged; then 0x100C.
- `br_reg_en`=1 target 0x4000 with `branch_taken`=1 -> `pc`=0x4000.
- `halt_req` at 0x1010 -> `halted`=1, `fetch_valid`=0, `pc` stays 0x1010 for 5 cycles; reset -> RESET_PC, BOOT.
- With `PC_MISALIGN_TRAP_EN`, BR target 0x4002 -> `misalign_err`=1, HALT, `pc` unchanged; `pc`=0xFFFF_FFFF_FFFF_FFFC sequential -> 0.
